// File: rtl/mem_bridge_pkg.sv
// Shared types for the core-to-AXI memory bridge.
// Optional watchdog enabled by MEM_BRIDGE_TIMEOUT_EN.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic is_busy(input state_t s);
    return (s == WADDR) || (s == WRESP) ||
           (s == RADDR) || (s == RDATA);
  endfunction

endpackage

// File: rtl/mem_bridge_wdog.sv
// Stall watchdog for the memory bridge; only built when
// MEM_BRIDGE_TIMEOUT_EN is defined.
module mem_bridge_wdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic restart,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (busy && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  // fires on the LIMIT-th cycle spent in one busy state
  assign expired = busy && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_axi_bridge.sv
// Core load/store to AXI4-Lite master bridge with core stall.
// Optional watchdog enabled by MEM_BRIDGE_TIMEOUT_EN.
module mem_axi_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 64,
  parameter int          STRB_W      = DATA_W / 8,
  parameter int          ID_W        = 4,
  parameter int unsigned TXN_ID      = 0,
  parameter int          TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ren_i,
  input  logic [ADDR_W-1:0] req_raddr_i,
  input  logic              req_wen_i,
  input  logic [ADDR_W-1:0] req_waddr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [STRB_W-1:0] req_wmask_i,
  output logic              hold_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic [ID_W-1:0]   m_awid_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [STRB_W-1:0] m_wstrb_o,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  input  logic [1:0]        m_bresp_i,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic [ID_W-1:0]   m_arid_o,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic [1:0]        m_rresp_i
);

  if (DATA_W % 8 != 0 || STRB_W != DATA_W / 8 ||
      TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("mem_axi_bridge: bad configuration");
  end

  state_t state, state_n, state_d;

  logic aw_done, w_done;
  logic rd_pend, rd_done, err_acc;
  logic aw_hs, w_hs, b_hs, r_hs;
  logic to, abort;

  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  assign aw_hs = m_awvalid_o && m_awready_i;
  assign w_hs  = m_wvalid_o && m_wready_i;
  assign b_hs  = m_bready_o && m_bvalid_i;
  assign r_hs  = m_rready_o && m_rvalid_i;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  mem_bridge_wdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst),
    .busy   (is_busy(state)),
    .restart(state_d != state),
    .expired(to)
  );
`else
  assign to = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req_wen_i)      state_n = WADDR;
        else if (req_ren_i) state_n = RADDR;
      end
      WADDR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs))
          state_n = WRESP;
      end
      WRESP: begin
        if (m_bvalid_i)
          state_n = rd_pend ? RADDR : DONE;
      end
      RADDR: if (m_arready_i) state_n = RDATA;
      RDATA: if (m_rvalid_i)  state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // a handshake that lands on the expiry cycle still wins
    abort   = to && (state_n == state);
    state_d = abort ? DONE : state_n;
  end

  always_comb begin
    hold_o      = 1'b0;
    rvalid_o    = 1'b0;
    err_o       = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    unique case (state)
      IDLE:  hold_o = req_ren_i || req_wen_i;
      WADDR: begin
        hold_o      = 1'b1;
        m_awvalid_o = !aw_done;
        m_wvalid_o  = !w_done;
      end
      WRESP: begin
        hold_o     = 1'b1;
        m_bready_o = 1'b1;
      end
      RADDR: begin
        hold_o      = 1'b1;
        m_arvalid_o = 1'b1;
      end
      RDATA: begin
        hold_o     = 1'b1;
        m_rready_o = 1'b1;
      end
      DONE: begin
        rvalid_o = rd_done;
        err_o    = err_acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rd_pend  <= 1'b0;
      rd_done  <= 1'b0;
      err_acc  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      araddr_q <= '0;
      rdata_o  <= '0;
    end else begin
      if (state == IDLE && (req_wen_i || req_ren_i)) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        rd_done <= 1'b0;
        err_acc <= 1'b0;
        rd_pend <= req_wen_i && req_ren_i;
        if (req_wen_i) begin
          awaddr_q <= req_waddr_i;
          wdata_q  <= req_wdata_i;
          wstrb_q  <= req_wmask_i;
        end
        if (req_ren_i) araddr_q <= req_raddr_i;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        rd_pend <= 1'b0;
        if (m_bresp_i != RESP_OKAY) err_acc <= 1'b1;
      end
      if (r_hs) begin
        rdata_o <= m_rdata_i;
        rd_done <= 1'b1;
        if (m_rresp_i != RESP_OKAY) err_acc <= 1'b1;
      end
      if (abort) begin
        err_acc <= 1'b1;
        rd_pend <= 1'b0;
        if (rd_pend || state == RADDR || state == RDATA) begin
          rdata_o <= '1;
          rd_done <= 1'b1;
        end
      end
    end
  end

  assign m_awaddr_o = awaddr_q;
  assign m_wdata_o  = wdata_q;
  assign m_wstrb_o  = wstrb_q;
  assign m_araddr_o = araddr_q;
  assign m_awid_o   = ID_W'(TXN_ID);
  assign m_arid_o   = ID_W'(TXN_ID);

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Self-checking bench for mem_axi_bridge: directed cases plus
// randomized transactions against a transaction-level model.
module tb_mem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_ren_i = 1'b0;
  logic [63:0] req_raddr_i = '0;
  logic        req_wen_i = 1'b0;
  logic [63:0] req_waddr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic [7:0]  req_wmask_i = '0;
  logic        hold_o, rvalid_o, err_o;
  logic [63:0] rdata_o;
  logic        m_awvalid_o, m_wvalid_o, m_bready_o;
  logic        m_arvalid_o, m_rready_o;
  logic [63:0] m_awaddr_o, m_wdata_o, m_araddr_o;
  logic [3:0]  m_awid_o, m_arid_o;
  logic [7:0]  m_wstrb_o;
  logic        m_awready_i = 1'b0;
  logic        m_wready_i = 1'b0;
  logic        m_bvalid_i = 1'b0;
  logic [1:0]  m_bresp_i = '0;
  logic        m_arready_i = 1'b0;
  logic        m_rvalid_i = 1'b0;
  logic [63:0] m_rdata_i = '0;
  logic [1:0]  m_rresp_i = '0;

  always #5 clk = ~clk;

  mem_axi_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .req_ren_i(req_ren_i), .req_raddr_i(req_raddr_i),
    .req_wen_i(req_wen_i), .req_waddr_i(req_waddr_i),
    .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .hold_o(hold_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_awaddr_o(m_awaddr_o), .m_awid_o(m_awid_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_bresp_i(m_bresp_i),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_araddr_o(m_araddr_o), .m_arid_o(m_arid_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i)
  );

  int vec = 0;
  int bad = 0;

  // slave configuration for the current transaction
  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  int          ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_c = 2'b00, rresp_c = 2'b00;
  logic [63:0] rdata_c = '0;

  // slave observations
  int          aw_wait = 0, w_wait = 0, b_wait = 0;
  int          ar_wait = 0, r_wait = 0;
  int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0;
  int          cyc = 0, b_t = 0, ar_t = 0;
  logic [63:0] aw_cap = '0, w_cap = '0, ar_cap = '0;
  logic [7:0]  strb_cap = '0;
  logic [3:0]  awid_cap = '0, arid_cap = '0;

  logic [63:0] model_rdata = '0;

  initial forever begin
    @(negedge clk);
    m_awready_i = m_awvalid_o && (aw_wait >= aw_dly);
    m_wready_i  = m_wvalid_o && (w_wait >= w_dly);
    m_arready_i = m_arvalid_o && (ar_wait >= ar_dly);
    m_bvalid_i  = m_bready_o && (b_wait >= b_dly);
    m_bresp_i   = m_bvalid_i ? bresp_c : 2'b00;
    m_rvalid_i  = m_rready_o && (r_wait >= r_dly);
    m_rresp_i   = m_rvalid_i ? rresp_c : 2'b00;
    m_rdata_i   = m_rvalid_i ? rdata_c : '0;
  end

  always @(posedge clk) begin
    cyc++;
    if (m_awvalid_o) aw_hi++;
    if (m_wvalid_o)  w_hi++;
    if (m_arvalid_o) ar_hi++;
    if (m_awvalid_o && m_awready_i) begin
      aw_n++; aw_cap = m_awaddr_o; awid_cap = m_awid_o; aw_wait = 0;
    end else if (m_awvalid_o) aw_wait++;
    if (m_wvalid_o && m_wready_i) begin
      w_n++; w_cap = m_wdata_o; strb_cap = m_wstrb_o; w_wait = 0;
    end else if (m_wvalid_o) w_wait++;
    if (m_bready_o && m_bvalid_i) begin
      b_n++; b_t = cyc; b_wait = 0;
    end else if (m_bready_o) b_wait++;
    if (m_arvalid_o && m_arready_i) begin
      ar_n++; ar_t = cyc; ar_cap = m_araddr_o;
      arid_cap = m_arid_o; ar_wait = 0;
    end else if (m_arvalid_o) ar_wait++;
    if (m_rready_o && m_rvalid_i) begin
      r_n++; r_wait = 0;
    end else if (m_rready_o) r_wait++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    aw_hi = 0; w_hi = 0; ar_hi = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
  endtask

  // Issue one core request and wait for completion; starts and ends
  // 1 time unit after a rising edge.
  task automatic run(input string tag, input bit wen, input bit ren,
                     input logic [63:0] waddr, input logic [63:0] raddr,
                     input logic [63:0] wdata, input logic [7:0] wmask);
    int n;
    int lat;
    bit exp_err;
    clear_obs();
    req_wen_i = wen; req_waddr_i = waddr;
    req_wdata_i = wdata; req_wmask_i = wmask;
    req_ren_i = ren; req_raddr_i = raddr;
    #1 check({tag, "_hold_c0"}, 64'(hold_o), 64'd1);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (hold_o && n < 200);
    lat = 1;
    if (wen) lat += ((aw_dly > w_dly) ? aw_dly : w_dly) + 1 + b_dly + 1;
    if (ren) lat += ar_dly + 1 + r_dly + 1;
    exp_err = (wen && bresp_c != 2'b00) || (ren && rresp_c != 2'b00);
    if (ren) model_rdata = rdata_c;
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_rvalid"}, 64'(rvalid_o), 64'(ren));
    check({tag, "_err"}, 64'(err_o), 64'(exp_err));
    check({tag, "_rdata"}, rdata_o, model_rdata);
    if (wen) begin
      check({tag, "_awaddr"}, aw_cap, waddr);
      check({tag, "_wdata"}, w_cap, wdata);
      check({tag, "_wstrb"}, 64'(strb_cap), 64'(wmask));
      check({tag, "_wr_hs"}, 64'({aw_n, w_n, b_n}),
            64'({32'd1, 32'd1, 32'd1}));
    end
    if (ren) begin
      check({tag, "_araddr"}, ar_cap, raddr);
      check({tag, "_rd_hs"}, 64'({ar_n, r_n}), 64'({32'd1, 32'd1}));
    end
    if (wen && ren) check({tag, "_b_before_ar"}, 64'(b_t < ar_t), 64'd1);
    req_wen_i = 1'b0; req_ren_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle"}, 64'({hold_o, rvalid_o, err_o}), 64'd0);
  endtask

  task automatic zero_wait();
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    bresp_c = 2'b00; rresp_c = 2'b00;
  endtask

  initial begin
    int kind;
    logic [63:0] ones;
    ones = '1;
    // reset state
    #12;
    check("reset_outs", 64'({hold_o, rvalid_o, err_o, m_awvalid_o,
          m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o}), 64'd0);
    check("reset_rdata", rdata_o, 64'd0);
    check("reset_addr", m_awaddr_o | m_araddr_o | m_wdata_o, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // zero-wait load
    zero_wait();
    rdata_c = 64'hDEAD_BEEF_0123_4567;
    run("load", 1'b0, 1'b1, '0, 64'h8000_0010, '0, '0);
    check("load_arid", 64'(arid_cap), 64'd0);

    // store, awready late by 2, wready immediate
    zero_wait(); aw_dly = 2;
    run("store_awdly", 1'b1, 1'b0, 64'h8000_0100,
        '0, 64'h1122_3344_5566_7788, 8'h0F);
    check("store_aw_hi", 64'(aw_hi), 64'd3);
    check("store_w_hi", 64'(w_hi), 64'd1);
    check("store_awid", 64'(awid_cap), 64'd0);

    // simultaneous store and load
    zero_wait(); rdata_c = 64'hCAFE_F00D_0000_0042;
    run("st_ld", 1'b1, 1'b1, 64'h8000_0200, 64'h8000_0208,
        64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);

    // load with slave error
    zero_wait(); rresp_c = 2'b10; rdata_c = 64'h0BAD_0BAD_1234_0000;
    run("load_slverr", 1'b0, 1'b1, '0, 64'h8000_0300, '0, '0);

    // write error then clean read: one err pulse in DONE
    zero_wait(); bresp_c = 2'b10; rdata_c = 64'h7777_6666_5555_4444;
    run("werr_rd", 1'b1, 1'b1, 64'h10, 64'h18, 64'h1, 8'h01);

    // reset during RDATA
    zero_wait(); r_dly = 20; clear_obs();
    req_ren_i = 1'b1; req_raddr_i = 64'h8000_0400;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; req_ren_i = 1'b0;
    #1;
    check("rst_mid_outs", 64'({hold_o, rvalid_o, err_o, m_rready_o,
          m_arvalid_o, m_awvalid_o, m_wvalid_o, m_bready_o}), 64'd0);
    check("rst_mid_rdata", rdata_o, 64'd0);
    check("rst_mid_araddr", m_araddr_o, 64'd0);
    model_rdata = '0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    zero_wait(); rdata_c = 64'h0123_4567_89AB_CDEF;
    run("post_rst_load", 1'b0, 1'b1, '0, 64'h8000_0500, '0, '0);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    begin
      int n;
      zero_wait(); ar_dly = 100000; clear_obs();
      req_ren_i = 1'b1; req_raddr_i = 64'h8000_0600;
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (hold_o && n < 200);
      model_rdata = ones;
      check("wdog_latency", 64'(n), 64'd9);
      check("wdog_ar_hi", 64'(ar_hi), 64'd8);
      check("wdog_ar_hs", 64'(ar_n), 64'd0);
      check("wdog_flags", 64'({rvalid_o, err_o}), 64'b11);
      check("wdog_rdata", rdata_o, model_rdata);
      req_ren_i = 1'b0;
      @(posedge clk); #1;
      check("wdog_idle", 64'({hold_o, m_arvalid_o}), 64'd0);
    end
`endif

    // randomized traffic with random wait states and responses
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      bresp_c = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
      rresp_c = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
      rdata_c = {$urandom, $urandom};
      run($sformatf("rnd%0d", i), kind != 0, kind != 1,
          {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
